// File: rtl/int_ctrl.sv
// Interrupt/exception initiator: latches IRQ edges and soft INTs, arbitrates by fixed
// priority, drives the hazard unit's interception window, issues the vector and sequences ERET.
module int_ctrl #(
  parameter int          NSRC      = 4,
  parameter logic [15:0] VEC_BASE  = 16'h0008,
  parameter int          FLUSH_CYC = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NSRC-1:0] irq_i,
  input  logic            mask_we_i,
  input  logic [NSRC-1:0] mask_i,
  input  logic            soft_int_i,
  input  logic [2:0]      soft_code_i,
  input  logic            eret_i,
  output logic            interception_o,
  output logic            vec_valid_o,
  output logic [15:0]     vec_pc_o,
  output logic            ret_o,
  output logic [3:0]      cause_o,
  output logic            in_service_o,
  output logic [NSRC-1:0] pending_o,
  output logic            overrun_o,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_VECTOR  = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [NSRC-1:0] irq_d_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q;
  logic [3:0]      cause_q;
  logic [15:0]     vec_pc_q;
  logic            interception_q;
  logic            vec_valid_q;
  logic            ret_q;
  logic            in_service_q;
  logic            overrun_q;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] enabled;
  logic [NSRC-1:0] clr;
  logic            hw_req;
  logic [2:0]      hw_idx;
  logic [15:0]     vec_pc_d;

  assign rise     = irq_i & ~irq_d_q;
  assign enabled  = pending_q & mask_q;
  assign hw_req   = |enabled;
  assign vec_pc_d = VEC_BASE + {10'b0, cause_q, 2'b00};

  // Scan from the top so the lowest enabled index is the one left standing.
  always_comb begin
    hw_idx = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (enabled[k]) hw_idx = 3'(k);
    end
  end

  always_comb begin
    clr = '0;
    if (state_q == S_VECTOR && !cause_q[3]) begin
      for (int k = 0; k < NSRC; k++) begin
        if (cause_q[2:0] == 3'(k)) clr[k] = 1'b1;
      end
    end
  end

  // A fresh edge wins over the clear of the source being vectored.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      irq_d_q   <= '0;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      irq_d_q   <= irq_i;
      pending_q <= pending_d;
      if (mask_we_i) mask_q <= mask_i;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cause_q        <= '0;
      vec_pc_q       <= '0;
      interception_q <= 1'b0;
      vec_valid_q    <= 1'b0;
      ret_q          <= 1'b0;
      in_service_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      vec_valid_q <= 1'b0;
      ret_q       <= 1'b0;
      if (soft_int_i && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (soft_int_i) begin
            cause_q        <= {1'b1, soft_code_i};
            cnt_q          <= CW'(FLUSH_CYC - 1);
            interception_q <= 1'b1;
            state_q        <= S_FLUSH;
          end else if (hw_req) begin
            cause_q        <= {1'b0, hw_idx};
            cnt_q          <= CW'(FLUSH_CYC - 1);
            interception_q <= 1'b1;
            state_q        <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            interception_q <= 1'b0;
            vec_valid_q    <= 1'b1;
            vec_pc_q       <= vec_pc_d;
            state_q        <= S_VECTOR;
          end
        end
        S_VECTOR: begin
          in_service_q <= 1'b1;
          state_q      <= S_SERVICE;
        end
        S_SERVICE: begin
          if (eret_i) begin
            in_service_q <= 1'b0;
            ret_q        <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          interception_q <= 1'b0;
          in_service_q   <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign interception_o = interception_q;
  assign vec_valid_o    = vec_valid_q;
  assign vec_pc_o       = vec_pc_q;
  assign ret_o          = ret_q;
  assign cause_o        = cause_q;
  assign in_service_o   = in_service_q;
  assign pending_o      = pending_q;
  assign overrun_o      = overrun_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed interrupt scenarios; vector issues are checked by a
// monitor against an expected queue of {cause, vec_pc}.
module tb_int_ctrl;
  localparam int NSRC      = 4;
  localparam int FLUSH_CYC = 3;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [NSRC-1:0] irq_i = '0;
  logic            mask_we_i = 1'b0;
  logic [NSRC-1:0] mask_i = '0;
  logic            soft_int_i = 1'b0;
  logic [2:0]      soft_code_i = '0;
  logic            eret_i = 1'b0;
  logic            interception_o;
  logic            vec_valid_o;
  logic [15:0]     vec_pc_o;
  logic            ret_o;
  logic [3:0]      cause_o;
  logic            in_service_o;
  logic [NSRC-1:0] pending_o;
  logic            overrun_o;
  logic [1:0]      dbg_state_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];

  int_ctrl #(.NSRC(NSRC), .VEC_BASE(16'h0008), .FLUSH_CYC(FLUSH_CYC)) dut (
    .CLK(CLK), .RST(RST), .irq_i(irq_i), .mask_we_i(mask_we_i), .mask_i(mask_i),
    .soft_int_i(soft_int_i), .soft_code_i(soft_code_i), .eret_i(eret_i),
    .interception_o(interception_o), .vec_valid_o(vec_valid_o), .vec_pc_o(vec_pc_o),
    .ret_o(ret_o), .cause_o(cause_o), .in_service_o(in_service_o),
    .pending_o(pending_o), .overrun_o(overrun_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_eret();
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
  endtask

  task automatic wait_service(input int budget);
    for (int i = 0; i < budget && !in_service_o; i++) tick();
    check("service_reached", 32'(in_service_o), 32'd1);
  endtask

  // monitor / scoreboard
  int icept_len = 0;
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        icept_len = 0;
      end else begin
        if (interception_o) begin
          icept_len++;
        end else if (icept_len != 0) begin
          check("icept_len", 32'(icept_len), 32'(FLUSH_CYC));
          icept_len = 0;
        end
        if (vec_valid_o) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL vec_unexpected: got pc %0h cause %0h expected no vector", vec_pc_o, cause_o);
          end else begin
            e = exp_q.pop_front();
            check("vec_cause", 32'(cause_o), 32'(e[19:16]));
            check("vec_pc", 32'(vec_pc_o), 32'(e[15:0]));
          end
        end
      end
    end
  end

  initial begin
    #2;
    check("rst_icept", 32'(interception_o), 32'd0);
    check("rst_vec_valid", 32'(vec_valid_o), 32'd0);
    check("rst_ret", 32'(ret_o), 32'd0);
    check("rst_cause", 32'(cause_o), 32'd0);
    check("rst_vec_pc", 32'(vec_pc_o), 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_in_service", 32'(in_service_o), 32'd0);
    tick();
    RST = 1'b1;

    // hardware source 2 with reset mask of all ones
    irq_i = 4'b0100;
    exp_q.push_back({4'h2, 16'h0010});
    tick();
    check("t1_pending", 32'(pending_o), 32'h4);
    check("t1_icept_e1", 32'(interception_o), 32'd0);
    tick();
    check("t1_icept_e2", 32'(interception_o), 32'd1);
    tick();
    check("t1_icept_e3", 32'(interception_o), 32'd1);
    tick();
    check("t1_icept_e4", 32'(interception_o), 32'd1);
    tick();
    check("t1_icept_e5", 32'(interception_o), 32'd0);
    check("t1_vec_valid_e5", 32'(vec_valid_o), 32'd1);
    tick();
    check("t1_in_service", 32'(in_service_o), 32'd1);
    check("t1_pending_clr", 32'(pending_o), 32'h0);
    check("t1_state", 32'(dbg_state_o), 32'd3);
    irq_i = '0;
    pulse_eret();
    check("t1_ret", 32'(ret_o), 32'd1);
    check("t1_in_service_off", 32'(in_service_o), 32'd0);
    tick();
    check("t1_ret_off", 32'(ret_o), 32'd0);

    // soft INT code 5
    soft_code_i = 3'b101;
    soft_int_i  = 1'b1;
    exp_q.push_back({4'hD, 16'h003C});
    tick();
    soft_int_i = 1'b0;
    check("t2_icept", 32'(interception_o), 32'd1);
    wait_service(10);
    check("t2_cause", 32'(cause_o), 32'hD);
    check("t2_overrun", 32'(overrun_o), 32'd0);
    pulse_eret();
    tick();

    // masked source 1, source 3 taken first
    mask_we_i = 1'b1;
    mask_i    = 4'b1101;
    tick();
    mask_we_i = 1'b0;
    irq_i     = 4'b1010;
    exp_q.push_back({4'h3, 16'h0014});
    tick();
    check("t3_pending_both", 32'(pending_o), 32'hA);
    wait_service(12);
    check("t3_cause", 32'(cause_o), 32'h3);
    check("t3_pending_left", 32'(pending_o), 32'h2);
    mask_we_i = 1'b1;
    mask_i    = 4'hF;
    tick();
    mask_we_i = 1'b0;
    exp_q.push_back({4'h1, 16'h000C});
    pulse_eret();
    check("t3_ret", 32'(ret_o), 32'd1);
    check("t3_icept_at_ret", 32'(interception_o), 32'd0);
    tick();
    check("t3_icept_after_ret", 32'(interception_o), 32'd1);
    check("t3_ret_off", 32'(ret_o), 32'd0);
    wait_service(12);
    check("t3_cause_irq1", 32'(cause_o), 32'h1);
    check("t3_pending_zero", 32'(pending_o), 32'h0);

    // edge on source 0 during service is held until after ERET
    irq_i = 4'b1011;
    tick();
    tick();
    check("t4_pending", 32'(pending_o), 32'h1);
    check("t4_no_icept", 32'(interception_o), 32'd0);
    check("t4_in_service", 32'(in_service_o), 32'd1);
    exp_q.push_back({4'h0, 16'h0008});
    pulse_eret();
    check("t4_ret", 32'(ret_o), 32'd1);
    check("t4_icept_at_ret", 32'(interception_o), 32'd0);
    tick();
    check("t4_icept_after_ret", 32'(interception_o), 32'd1);
    wait_service(12);
    check("t4_cause", 32'(cause_o), 32'h0);
    irq_i = '0;

    // soft INT during service is dropped; ERET in IDLE is ignored
    soft_code_i = 3'b010;
    soft_int_i  = 1'b1;
    tick();
    soft_int_i = 1'b0;
    check("t5_overrun", 32'(overrun_o), 32'd1);
    check("t5_state", 32'(dbg_state_o), 32'd3);
    check("t5_no_icept", 32'(interception_o), 32'd0);
    tick();
    check("t5_still_service", 32'(in_service_o), 32'd1);
    pulse_eret();
    check("t5_ret", 32'(ret_o), 32'd1);
    tick();
    pulse_eret();
    check("t5_idle_eret", 32'(ret_o), 32'd0);
    check("t5_idle_icept", 32'(interception_o), 32'd0);

    // reset on the second flush cycle
    soft_code_i = 3'b000;
    soft_int_i  = 1'b1;
    tick();
    soft_int_i = 1'b0;
    check("t6_icept_c1", 32'(interception_o), 32'd1);
    tick();
    check("t6_icept_c2", 32'(interception_o), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("t6_icept_async", 32'(interception_o), 32'd0);
    check("t6_pending", 32'(pending_o), 32'h0);
    check("t6_overrun", 32'(overrun_o), 32'd0);
    check("t6_state", 32'(dbg_state_o), 32'd0);
    repeat (3) tick();
    RST = 1'b1;
    repeat (10) tick();
    check("t6_no_vector", 32'(vec_valid_o), 32'd0);
    check("exp_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
